// File: rtl/uart_tx_unit.sv
// uart_tx_unit
//   Byte FIFO followed by an 8N1 serial transmitter. Bytes from the store
//   port are queued. They are then shifted out LSB first on uart_tx, framed by
//   one start bit (low) and one stop bit (high). Queued bytes go out back to
//   back with no idle gap between frames.
`timescale 1ns/1ps

module uart_tx_unit #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        uart_tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    state_t            state;
    logic [7:0]        shift;
    logic [2:0]        bit_idx;
    logic [BAUD_W-1:0] baud;

    logic              push;
    logic              pop;
    logic              baud_done;
    logic              fifo_empty;

    // Ready depends only on the registered level, so a full FIFO refuses a
    // push even on a cycle where the transmitter pops.
    assign fifo_empty = (fifo_level == '0);
    assign tx_ready   = (fifo_level != LVL_FULL);
    assign push       = tx_valid && tx_ready;
    assign baud_done  = (baud == BAUD_LAST);
    assign busy       = (state != IDLE) || !fifo_empty;

    // The transmitter takes the next byte when idle, or at the very end of a stop bit.
    always_comb begin
        // NOTE: pop gets a default before the case so every path assigns it and no latch is inferred.
        pop = 1'b0;
        case (state)
            IDLE:    pop = !fifo_empty;
            STOP:    pop = baud_done && !fifo_empty;
            default: pop = 1'b0;
        endcase
    end

    // Byte storage, written on every accepted push.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset. An entry is only read after it has been written, so it can map onto plain RAM.
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers and occupancy. Pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register here samples the pre-edge values of push/pop.
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Frame sequencer: start bit, eight data bits LSB first, stop bit. The line is driven from a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            uart_tx <= 1'b1;
            shift   <= '0;
            bit_idx <= '0;
            baud    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    baud    <= '0;
                    uart_tx <= 1'b1;
                    if (pop) begin
                        shift   <= mem[rd_ptr];
                        state   <= START;
                        uart_tx <= 1'b0;
                    end
                end

                START: begin
                    if (baud_done) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                        uart_tx <= shift[0];
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end

                DATA: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            state   <= STOP;
                            uart_tx <= 1'b1;
                        end else begin
                            shift   <= {1'b0, shift[7:1]};
                            uart_tx <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end

                STOP: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (pop) begin
                            shift   <= mem[rd_ptr];
                            state   <= START;
                            uart_tx <= 1'b0;
                        end else begin
                            state   <= IDLE;
                            uart_tx <= 1'b1;
                        end
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end

                default: begin
                    state   <= IDLE;
                    uart_tx <= 1'b1;
                    baud    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_unit.sv
// tb_uart_tx_unit
//   Self-checking bench for uart_tx_unit with CLKS_PER_BIT=4, FIFO_DEPTH=4.
//   Frame table vectors and hand sequences for the FIFO corner cases come first.
//   Then a randomized run is compared against a frame-position reference model.
`timescale 1ns/1ps

module tb_uart_tx_unit;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       uart_tx;
    logic       busy;
    logic [2:0] fifo_level;

    uart_tx_unit #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .uart_tx   (uart_tx),
        .busy      (busy),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: inputs set before the call are sampled at the edge, and outputs are read 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------
    // Line monitor: decodes 8N1 frames at bit centres into a byte queue.
    // ---------------------------------------------------------------
    logic [7:0] rx_q[$];
    logic       rx_stop_q[$];
    int         mon_glitch = 0;
    bit         mon_active = 1'b0;
    int         mon_cnt    = 0;
    logic [7:0] mon_sh     = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                mon_active = 1'b0;
            end else if (!mon_active) begin
                if (uart_tx === 1'b0) begin
                    mon_active = 1'b1;
                    mon_cnt    = 0;
                end
            end else begin
                mon_cnt++;
                if (mon_cnt == CPB / 2) begin
                    if (uart_tx !== 1'b0) begin
                        mon_active = 1'b0;
                        mon_glitch++;
                    end
                end else if (mon_cnt == CPB / 2 + 9 * CPB) begin
                    rx_q.push_back(mon_sh);
                    rx_stop_q.push_back(uart_tx);
                    mon_active = 1'b0;
                end else if (mon_cnt > CPB / 2 && (mon_cnt - CPB / 2) % CPB == 0) begin
                    mon_sh = {uart_tx, mon_sh[7:1]};
                end
            end
        end
    end

    task automatic clear_rx();
        rx_q.delete();
        rx_stop_q.delete();
    endtask

    task automatic expect_rx(input string name, input logic [7:0] exp);
        logic [7:0] got;
        logic       stop;
        if (rx_q.size() == 0) begin
            check({name, "_present"}, 32'(rx_q.size()), 1);
        end else begin
            got  = rx_q.pop_front();
            stop = rx_stop_q.pop_front();
            check({name, "_byte"}, got, exp);
            check({name, "_stop"}, stop, 1);
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        check(name, busy, 0);
    endtask

    task automatic wait_level(input string name, input logic [2:0] target, input int budget);
        int n;
        n = 0;
        while (fifo_level !== target && n < budget) begin
            tick();
            n++;
        end
        check(name, fifo_level, target);
    endtask

    // ---------------------------------------------------------------
    // Reference model: a byte queue plus a frame position counter.
    // The line level is read off the 10-bit frame at position m_t/CPB.
    // ---------------------------------------------------------------
    logic [7:0] mq[$];
    bit         m_active;
    int         m_t;
    logic [7:0] m_cur;

    task automatic model_reset();
        mq.delete();
        m_active = 1'b0;
        m_t      = 0;
        m_cur    = '0;
    endtask

    task automatic model_edge(input logic v, input logic [7:0] d);
        bit ready;
        bit do_push;
        bit frame_end;
        bit do_pop;
        ready     = (mq.size() != DEPTH);
        do_push   = v && ready;
        frame_end = m_active && (m_t == FRAME - 1);
        do_pop    = (mq.size() != 0) && (!m_active || frame_end);
        if (m_active) m_t++;
        if (frame_end) m_active = 1'b0;
        if (do_pop) begin
            m_cur    = mq.pop_front();
            m_active = 1'b1;
            m_t      = 0;
        end
        if (do_push) mq.push_back(d);
    endtask

    function automatic logic model_line();
        int idx;
        if (!m_active) return 1'b1;
        idx = m_t / CPB;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return m_cur[idx-1];
    endfunction

    // ---------------------------------------------------------------
    // Frame table: byte and its line pattern in send order (bit 9 first).
    // ---------------------------------------------------------------
    typedef struct {
        logic [7:0] data;
        logic [9:0] bits;
    } frame_vec_t;

    frame_vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] obs;
        logic       bit_val;
        logic       steady;
        int         cyc;
        int         bad_line;
        int         bad_ready;
        int         bad_busy;
        int         rate;

        vecs[0] = '{data: 8'hA5, bits: 10'b0101001011};
        vecs[1] = '{data: 8'h00, bits: 10'b0000000001};
        vecs[2] = '{data: 8'hFF, bits: 10'b0111111111};
        vecs[3] = '{data: 8'h01, bits: 10'b0100000001};
        vecs[4] = '{data: 8'h80, bits: 10'b0000000011};
        vecs[5] = '{data: 8'h3C, bits: 10'b0001111001};

        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;

        // Reset state
        tick();
        check("rst_uart_tx", uart_tx, 1);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_fifo_level", fifo_level, 0);
        tick();
        rst = 1'b0;

        // Idle for 100 cycles with no traffic
        bad_line  = 0;
        bad_ready = 0;
        bad_busy  = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (uart_tx !== 1'b1) bad_line++;
            if (tx_ready !== 1'b1) bad_ready++;
            if (busy !== 1'b0) bad_busy++;
        end
        check("idle_line_low_cycles", bad_line, 0);
        check("idle_not_ready_cycles", bad_ready, 0);
        check("idle_busy_cycles", bad_busy, 0);

        // Single frames from the table
        for (int v = 0; v < 6; v++) begin
            clear_rx();
            tx_valid = 1'b1;
            tx_data  = vecs[v].data;
            tick();                         // accept edge
            tx_valid = 1'b0;
            check("t1_level_after_accept", fifo_level, 1);
            check("t1_line_high_before_pop", uart_tx, 1);
            tick();                         // pop edge: start bit begins
            obs = '0;
            for (int k = 0; k < 10; k++) begin
                bit_val = uart_tx;
                steady  = 1'b1;
                for (int c = 0; c < CPB; c++) begin
                    if (uart_tx !== bit_val) steady = 1'b0;
                    tick();
                end
                obs[9-k] = steady ? bit_val : ~vecs[v].bits[9-k];
            end
            check("t1_frame_bits", obs, vecs[v].bits);
            check("t1_busy_after_frame", busy, 0);
            check("t1_line_after_frame", uart_tx, 1);
            expect_rx("t1_rx", vecs[v].data);
        end

        // Two bytes on consecutive cycles: frames back to back
        clear_rx();
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        tick();
        check("t2_level_a", fifo_level, 1);
        tx_data = 8'hFF;
        tick();
        tx_valid = 1'b0;
        check("t2_level_b", fifo_level, 1);
        check("t2_first_start", uart_tx, 0);
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            if (cyc == 1) check("t2_level_c", fifo_level, 1);
            if (cyc == 39) check("t2_stop_before_second", uart_tx, 1);
            if (cyc == 40) begin
                check("t2_level_after_second_pop", fifo_level, 0);
                check("t2_second_start_no_gap", uart_tx, 0);
            end
            tick();
            cyc++;
        end
        check("t2_two_frame_cycles", cyc, 2 * FRAME);
        expect_rx("t2_rx0", 8'h00);
        expect_rx("t2_rx1", 8'hFF);
        check("t2_no_extra_frames", rx_q.size(), 0);

        // tx_valid held for six cycles: fifth byte fills, sixth dropped
        clear_rx();
        for (int i = 0; i < 6; i++) begin
            tx_valid = 1'b1;
            tx_data  = 8'(i + 1);
            tick();
            check("t3_level", fifo_level, (i < 2) ? 1 : ((i < 4) ? i : 4));
            check("t3_ready", tx_ready, (i < 4) ? 1 : 0);
            if (i == 1) check("t3_first_pop_start", uart_tx, 0);
        end
        tx_valid = 1'b0;
        wait_idle("t3_drain", 1000);
        for (int i = 1; i <= 5; i++) begin
            expect_rx("t3_rx", 8'(i));
        end
        check("t3_dropped_sixth", rx_q.size(), 0);

        // Full FIFO with simultaneous pop and push, then push+pop at level 2
        clear_rx();
        for (int i = 0; i < 5; i++) begin
            tx_valid = 1'b1;
            tx_data  = 8'h11 + 8'(i);
            tick();
        end
        check("t4_full_level", fifo_level, 4);
        check("t4_full_not_ready", tx_ready, 0);
        tx_data = 8'h77;
        wait_level("t4_refused_push_level", 3, 100);
        tx_valid = 1'b0;
        check("t4_ready_after_pop", tx_ready, 1);
        wait_level("t4_level_two", 2, 100);
        repeat (FRAME - 1) tick();
        check("t4_level_before_pushpop", fifo_level, 2);
        tx_valid = 1'b1;
        tx_data  = 8'h88;
        tick();
        tx_valid = 1'b0;
        check("t4_level_pushpop", fifo_level, 2);
        wait_idle("t4_drain", 1000);
        for (int i = 0; i < 5; i++) begin
            expect_rx("t4_rx", 8'h11 + 8'(i));
        end
        expect_rx("t4_rx_late", 8'h88);
        check("t4_no_extra_frames", rx_q.size(), 0);

        // Reset in the middle of data bit 3 with two bytes queued
        clear_rx();
        for (int i = 0; i < 3; i++) begin
            tx_valid = 1'b1;
            tx_data  = 8'h50 + 8'(i);
            tick();
        end
        tx_valid = 1'b0;
        repeat (16) tick();
        check("t5_level_before_rst", fifo_level, 2);
        check("t5_line_low_in_bit3", uart_tx, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_line_after_rst", uart_tx, 1);
        check("t5_level_after_rst", fifo_level, 0);
        check("t5_busy_after_rst", busy, 0);
        check("t5_ready_after_rst", tx_ready, 1);
        bad_line = 0;
        bad_busy = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (uart_tx !== 1'b1) bad_line++;
            if (busy !== 1'b0) bad_busy++;
        end
        check("t5_no_resumed_frame", bad_line, 0);
        check("t5_stays_idle", bad_busy, 0);
        check("t5_no_rx_bytes", rx_q.size(), 0);

        // Randomized traffic against the reference model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            case ((c / 500) % 3)
                0:       rate = 10;
                1:       rate = 60;
                default: rate = 95;
            endcase
            tx_valid = ($urandom_range(0, 99) < rate);
            tx_data  = 8'($urandom_range(0, 255));
            model_edge(tx_valid, tx_data);
            tick();
            check("rnd_uart_tx", uart_tx, model_line());
            check("rnd_fifo_level", fifo_level, mq.size());
            check("rnd_tx_ready", tx_ready, (mq.size() != DEPTH) ? 1 : 0);
            check("rnd_busy", busy, (m_active || mq.size() != 0) ? 1 : 0);
        end
        tx_valid = 1'b0;
        wait_idle("rnd_drain", 1000);
        check("monitor_start_glitches", mon_glitch, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
